ctx_stack_file: RTL and testbench
=================================

# ctx_stack_file

Parametrised, multi-context return-address stack for the processor's call/return path. It holds one independent LIFO per software context (process), selected by the OS-visible context number, so a context switch needs no spill or refill of return addresses. It adds simultaneous push/pop, per-context flush, occupancy reporting and encoded sticky errors, and is the drop-in successor of the single-context stack in the control unit.

## Interface
- ADDR_W, 13: return-address width.
- DEPTH, 64: entries per context; power of two, at least 2.
- NUM_CTX, 4: number of contexts; power of two, at least 1.
- Slow_Clock  in  1  processor clock; all state changes on its falling edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Ctx_Sel  in  max(1,clog2(NUM_CTX))  context addressed by this cycle's operation and by all status outputs.
- Push  in  1  store Push_Data on the top of the selected stack.
- Pop  in  1  remove the top entry and return it on Ret_Add.
- Flush  in  1  empty the selected context and clear its error.
- Err_Clear  in  1  clear the selected context's error code only.
- Push_Data  in  ADDR_W  address to push (next PC).
- Ret_Add  out  ADDR_W  registered; holds the last popped value.
- Ret_Valid  out  1  registered; pulses for one cycle after a successful pop.
- Full, Empty  out  1  combinational status of the selected context.
- Depth_Out  out  clog2(DEPTH)+1  occupancy of the selected context (0..DEPTH).
- Err_Out  out  2  sticky error of the selected context: 00 none, 01 overflow, 10 underflow.

## Operation
- Storage is one array of NUM_CTX*DEPTH words, indexed {ctx, slot}. Each context has a count (0..DEPTH) and a base slot (used only with wrap). Reset does not clear array contents.
- Priority on each falling edge, for the selected context only: Flush, then Err_Clear, then Push/Pop. Unselected contexts never change.
- Flush: count becomes 0, base becomes 0, error becomes 00. Any concurrent Push or Pop is ignored.
- Err_Clear: error becomes 00. A Push or Pop in the same cycle still executes and may set a new error, which takes precedence.
- Push only, not full: write slot (base+count) mod DEPTH, then increment count.
- Pop only, not empty: Ret_Add takes slot (base+count-1) mod DEPTH, count decrements, Ret_Valid is 1.
- Push and Pop, not empty (tail call): Ret_Add takes the current top, Push_Data overwrites the same slot, count is unchanged, Ret_Valid is 1.
- Pop, or Push+Pop, when empty: error becomes 10. Nothing else changes and Ret_Valid is 0.
- Push when full: see Configuration.
- Errors are sticky until Flush or Err_Clear. A later successful operation does not clear them.

## Timing
- Reset (asynchronous, Reset_n low): all counts and bases go to 0, every error to 00, Ret_Add to 0, Ret_Valid to 0. Resetting mid-operation abandons the operation and leaves the array undefined as far as the design cares.
- Latency: a pop's data appears on Ret_Add and Ret_Valid after the same falling edge that samples Pop. Ret_Add holds its value until the next successful pop.
- Full, Empty, Depth_Out and Err_Out follow Ctx_Sel combinationally. They reflect the state after the most recent falling edge.
- Back-to-back operations are supported on every edge, with no bubbles, including a pop immediately after a push of the same entry.

## Configuration
- STACK_WRAP_EN defined: a push on a full context overwrites the oldest entry. Base advances by 1 mod DEPTH, count stays DEPTH, and no error is raised.
- STACK_WRAP_EN undefined: a push on a full context is dropped and the error becomes 01. Base registers are not built and are treated as 0.

## Structure
- Shared package stack_pkg holds the error code constants (ERR_NONE, ERR_OVF, ERR_UDF) and the clog2-derived width helpers.
- Sub-module stack_ctx_ctrl is instantiated NUM_CTX times. It holds the count, base and error for one context and produces full, empty, top-slot and write-slot. The top level holds the array, the Ret_Add/Ret_Valid registers and the Ctx_Sel muxing.

## Test plan
- Reset, then push 0x0100, 0x0200, 0x0300 on ctx 0, then pop three times -> Ret_Add reads 0x0300, 0x0200, 0x0100; Ret_Valid is high each cycle; Empty is 1 and Err_Out is 00 at the end.
- Push 0x0AAA on ctx 1 and 0x0BBB on ctx 2, then pop ctx 1 -> 0x0AAA; ctx 2 still shows Depth_Out 1; pop ctx 2 -> 0x0BBB.
- Ctx 0 holds 0x0010; Push+Pop with Push_Data 0x0020 -> Ret_Add 0x0010, Depth_Out stays 1; the next pop returns 0x0020.
- Pop on an empty ctx 3 -> Err_Out 10, Ret_Valid 0, Ret_Add unchanged; Err_Clear -> Err_Out 00.
- Push 65 values 1..65 on ctx 0 with DEPTH 64 -> without wrap: Err_Out 01, the pop returns 64. With STACK_WRAP_EN: no error; 64 pops return 65 down to 2.
- Push 3 values on ctx 2, then Flush asserted together with Pop -> Depth_Out 0, Ret_Valid 0; pulse Reset_n low mid-sequence -> Ret_Add 0 and every context is empty.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: shared constants and width helpers for the multi-context
// return-address stack (ctx_stack_file and stack_ctx_ctrl).
//   ERR_NONE / ERR_OVF / ERR_UDF : 2-bit sticky error codes
//   sel_width(n)    : width of a context selector for n contexts (min 1)
//   slot_width(d)   : width of a slot index inside one context
//   count_width(d)  : width of an occupancy count 0..d
package stack_pkg;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UDF  = 2'b10;

   function automatic int sel_width(input int num_ctx);
      if (num_ctx > 1) begin
         return $clog2(num_ctx);
      end else begin
         return 1;
      end
   endfunction

   function automatic int slot_width(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stack_ctx_ctrl.sv
// stack_ctx_ctrl: bookkeeping for one context of the return-address stack.
// Holds the occupancy count, the base slot (wrap builds only) and the sticky
// error code, and tells the top level where to write and where the top is.
// Ports:
//   clk, rst_n        falling-edge clock, async active-low reset
//   sel               this context is the one addressed this cycle
//   push, pop, flush, err_clear   operation requests (only act when sel)
//   count, err        occupancy (0..DEPTH) and sticky error code
//   full, empty       occupancy status
//   top_slot          slot holding the current top entry
//   wr_slot           slot to write this cycle (top on tail call, else append)
//   wr_en             a write into the array happens this cycle
//   pop_ok            a successful pop (or tail call) happens this cycle
// Macro STACK_WRAP_EN: a push on a full context overwrites the oldest entry
// instead of raising an overflow error; base registers exist only then.
module stack_ctx_ctrl
   import stack_pkg::*;
#(
   parameter int DEPTH = 64
)
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          sel,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   input  logic                          err_clear,
   output logic [count_width(DEPTH)-1:0] count,
   output logic [1:0]                    err,
   output logic                          full,
   output logic                          empty,
   output logic [slot_width(DEPTH)-1:0]  top_slot,
   output logic [slot_width(DEPTH)-1:0]  wr_slot,
   output logic                          wr_en,
   output logic                          pop_ok
);

   localparam int SW = slot_width(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [CW-1:0] count_r;
   logic [1:0]    err_r;
   logic [SW-1:0] base_s;
   logic [SW-1:0] top_slot_s;
   logic [SW-1:0] append_slot_s;
   logic          full_s;
   logic          empty_s;
   logic          act_s;
   logic          push_pop_s;
   logic          push_only_s;
   logic          pop_only_s;
   logic          inc_s;
   logic          dec_s;
   logic          wrap_s;
   logic          ovf_s;
   logic          udf_s;

`ifdef STACK_WRAP_EN
   localparam logic WRAP_EN = 1'b1;
   logic [SW-1:0] base_r;

   // Base slot: oldest entry moves forward by one on every wrapping push.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_r <= {SW{1'b0}};
      end else if (sel && flush) begin
         base_r <= {SW{1'b0}};
      end else if (wrap_s) begin
         base_r <= base_r + SW'(1'b1);
      end
   end

   assign base_s = base_r;
`else
   localparam logic WRAP_EN = 1'b0;
   assign base_s = {SW{1'b0}};
`endif

   // Slot arithmetic is modulo DEPTH through truncation to SW bits; a full
   // context has count[SW-1:0]==0, so append_slot lands on the oldest entry.
   assign top_slot_s    = base_s + count_r[SW-1:0] - SW'(1'b1);
   assign append_slot_s = base_s + count_r[SW-1:0];

   // Decode the requested operation for this context.
   always_comb begin
      full_s      = (count_r == CW'(DEPTH));
      empty_s     = (count_r == {CW{1'b0}});
      act_s       = sel & ~flush;
      push_pop_s  = act_s & push & pop;
      push_only_s = act_s & push & ~pop;
      pop_only_s  = act_s & pop & ~push;
      pop_ok      = (push_pop_s | pop_only_s) & ~empty_s;
      udf_s       = (push_pop_s | pop_only_s) & empty_s;
      inc_s       = push_only_s & ~full_s;
      dec_s       = pop_only_s & ~empty_s;
      wrap_s      = WRAP_EN & push_only_s & full_s;
      ovf_s       = ~WRAP_EN & push_only_s & full_s;
      wr_en       = (push_pop_s & ~empty_s) | inc_s | wrap_s;
      if (push_pop_s) begin
         wr_slot = top_slot_s;
      end else begin
         wr_slot = append_slot_s;
      end
   end

   // Occupancy and sticky error; a new error outranks a same-cycle clear.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CW{1'b0}};
         err_r   <= ERR_NONE;
      end else if (sel && flush) begin
         count_r <= {CW{1'b0}};
         err_r   <= ERR_NONE;
      end else begin
         if (inc_s) begin
            count_r <= count_r + CW'(1'b1);
         end else if (dec_s) begin
            count_r <= count_r - CW'(1'b1);
         end
         if (udf_s) begin
            err_r <= ERR_UDF;
         end else if (ovf_s) begin
            err_r <= ERR_OVF;
         end else if (sel && err_clear) begin
            err_r <= ERR_NONE;
         end
      end
   end

   assign count    = count_r;
   assign err      = err_r;
   assign full     = full_s;
   assign empty    = empty_s;
   assign top_slot = top_slot_s;

endmodule

// File: rtl/ctx_stack_file.sv
// ctx_stack_file: multi-context return-address stack. One independent LIFO
// per context, selected by Ctx_Sel, so a context switch needs no spill.
// Ports:
//   Slow_Clock   processor clock, all state changes on its falling edge
//   Reset_n      asynchronous active-low reset
//   Ctx_Sel      context addressed by the operation and the status outputs
//   Push/Pop     push Push_Data / pop top (both together = tail call)
//   Flush        empty the selected context and clear its error
//   Err_Clear    clear the selected context's error only
//   Ret_Add      registered, last popped value (held until next pop)
//   Ret_Valid    registered, one-cycle pulse after a successful pop
//   Full/Empty/Depth_Out/Err_Out  status of the selected context
// Macro STACK_WRAP_EN: push on a full context overwrites the oldest entry.
module ctx_stack_file
   import stack_pkg::*;
#(
   parameter int ADDR_W  = 13,
   parameter int DEPTH   = 64,
   parameter int NUM_CTX = 4
)
(
   input  logic                          Slow_Clock,
   input  logic                          Reset_n,
   input  logic [sel_width(NUM_CTX)-1:0] Ctx_Sel,
   input  logic                          Push,
   input  logic                          Pop,
   input  logic                          Flush,
   input  logic                          Err_Clear,
   input  logic [ADDR_W-1:0]             Push_Data,
   output logic [ADDR_W-1:0]             Ret_Add,
   output logic                          Ret_Valid,
   output logic                          Full,
   output logic                          Empty,
   output logic [count_width(DEPTH)-1:0] Depth_Out,
   output logic [1:0]                    Err_Out
);

   localparam int XW = sel_width(NUM_CTX);
   localparam int SW = slot_width(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [ADDR_W-1:0] mem_r [NUM_CTX][DEPTH];

   logic [NUM_CTX-1:0] sel_s;
   logic [NUM_CTX-1:0] full_s;
   logic [NUM_CTX-1:0] empty_s;
   logic [NUM_CTX-1:0] wr_en_s;
   logic [NUM_CTX-1:0] pop_ok_s;
   logic [CW-1:0]      count_s    [NUM_CTX];
   logic [1:0]         err_s      [NUM_CTX];
   logic [SW-1:0]      top_slot_s [NUM_CTX];
   logic [SW-1:0]      wr_slot_s  [NUM_CTX];

   // One-hot decode of the addressed context.
   always_comb begin
      for (int c = 0; c < NUM_CTX; c++) begin
         sel_s[c] = (Ctx_Sel == XW'(c));
      end
   end

   for (genvar c = 0; c < NUM_CTX; c++) begin : g_ctx
      stack_ctx_ctrl #(
         .DEPTH (DEPTH)
      ) u_ctrl (
         .clk       (Slow_Clock),
         .rst_n     (Reset_n),
         .sel       (sel_s[c]),
         .push      (Push),
         .pop       (Pop),
         .flush     (Flush),
         .err_clear (Err_Clear),
         .count     (count_s[c]),
         .err       (err_s[c]),
         .full      (full_s[c]),
         .empty     (empty_s[c]),
         .top_slot  (top_slot_s[c]),
         .wr_slot   (wr_slot_s[c]),
         .wr_en     (wr_en_s[c]),
         .pop_ok    (pop_ok_s[c])
      );
   end

   // Entry storage; intentionally not reset. On a tail call the read below
   // sees the old top because both updates are non-blocking.
   always_ff @(negedge Slow_Clock) begin
      if (wr_en_s[Ctx_Sel]) begin
         mem_r[Ctx_Sel][wr_slot_s[Ctx_Sel]] <= Push_Data;
      end
   end

   // Return address register and its one-cycle valid pulse.
   always_ff @(negedge Slow_Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         Ret_Add   <= {ADDR_W{1'b0}};
         Ret_Valid <= 1'b0;
      end else begin
         Ret_Valid <= pop_ok_s[Ctx_Sel];
         if (pop_ok_s[Ctx_Sel]) begin
            Ret_Add <= mem_r[Ctx_Sel][top_slot_s[Ctx_Sel]];
         end
      end
   end

   // Status of the selected context.
   always_comb begin
      Full      = full_s[Ctx_Sel];
      Empty     = empty_s[Ctx_Sel];
      Depth_Out = count_s[Ctx_Sel];
      Err_Out   = err_s[Ctx_Sel];
   end

endmodule

// File: tb/tb_ctx_stack_file.sv
// tb_ctx_stack_file: self-checking bench for ctx_stack_file. A queue-per-
// context reference model tracks expected contents, errors and Ret_Add.
// Honours STACK_WRAP_EN the same way as the design.
module tb_ctx_stack_file;
   import stack_pkg::*;

   localparam int ADDR_W  = 13;
   localparam int DEPTH   = 64;
   localparam int NUM_CTX = 4;
   localparam int CW      = $clog2(DEPTH) + 1;
`ifdef STACK_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic              Slow_Clock = 1'b0;
   logic              Reset_n;
   logic [1:0]        Ctx_Sel;
   logic              Push, Pop, Flush, Err_Clear;
   logic [ADDR_W-1:0] Push_Data;
   logic [ADDR_W-1:0] Ret_Add;
   logic              Ret_Valid, Full, Empty;
   logic [CW-1:0]     Depth_Out;
   logic [1:0]        Err_Out;

   logic [ADDR_W-1:0] mq [NUM_CTX][$];
   logic [1:0]        merr [NUM_CTX];
   logic [ADDR_W-1:0] mret;
   logic              mrv;
   int checks;
   int failures;

   ctx_stack_file #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_CTX(NUM_CTX)) dut (
      .Slow_Clock (Slow_Clock),
      .Reset_n    (Reset_n),
      .Ctx_Sel    (Ctx_Sel),
      .Push       (Push),
      .Pop        (Pop),
      .Flush      (Flush),
      .Err_Clear  (Err_Clear),
      .Push_Data  (Push_Data),
      .Ret_Add    (Ret_Add),
      .Ret_Valid  (Ret_Valid),
      .Full       (Full),
      .Empty      (Empty),
      .Depth_Out  (Depth_Out),
      .Err_Out    (Err_Out)
   );

   always #5 Slow_Clock = ~Slow_Clock;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   task automatic model_reset();
      for (int i = 0; i < NUM_CTX; i++) begin
         mq[i].delete();
         merr[i] = ERR_NONE;
      end
      mret = '0;
      mrv  = 1'b0;
   endtask

   // Drive one operation (just after a rising edge), update the model, let
   // the falling edge apply it, and return at the next rising edge idle.
   task automatic step(input int c, input bit pu, input bit po, input bit fl,
                       input bit ec, input logic [ADDR_W-1:0] d);
      Ctx_Sel = c[1:0]; Push = pu; Pop = po; Flush = fl; Err_Clear = ec; Push_Data = d;
      mrv = 1'b0;
      if (fl) begin
         mq[c].delete();
         merr[c] = ERR_NONE;
      end else begin
         if (ec) merr[c] = ERR_NONE;
         if (po) begin
            if (mq[c].size() == 0) merr[c] = ERR_UDF;
            else if (pu) begin
               mret = mq[c][mq[c].size()-1];
               mq[c][mq[c].size()-1] = d;
               mrv = 1'b1;
            end else begin
               mret = mq[c].pop_back();
               mrv = 1'b1;
            end
         end else if (pu) begin
            if (mq[c].size() < DEPTH) mq[c].push_back(d);
            else if (WRAP) begin
               void'(mq[c].pop_front());
               mq[c].push_back(d);
            end else merr[c] = ERR_OVF;
         end
      end
      @(negedge Slow_Clock);
      @(posedge Slow_Clock);
      Push = 1'b0; Pop = 1'b0; Flush = 1'b0; Err_Clear = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (Ret_Add !== 13'h0 || Ret_Valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_ret got=%h/%b exp=0000/0", Ret_Add, Ret_Valid);
      end
      for (int i = 0; i < NUM_CTX; i++) begin
         Ctx_Sel = i[1:0];
         #1;
         checks++;
         if (Depth_Out !== 7'd0 || Empty !== 1'b1 || Full !== 1'b0 || Err_Out !== 2'b00) begin
            failures++;
            $display("FAIL reset_status ctx=%0d got depth=%0d empty=%b full=%b err=%b exp 0/1/0/00",
                     i, Depth_Out, Empty, Full, Err_Out);
         end
      end
      @(posedge Slow_Clock);
      Reset_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [ADDR_W-1:0] exp_v [3];
      exp_v[0] = 13'h0300; exp_v[1] = 13'h0200; exp_v[2] = 13'h0100;
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0100);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0200);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0300);
      for (int k = 0; k < 3; k++) begin
         step(0, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0);
         checks++;
         if (Ret_Add !== exp_v[k] || Ret_Valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_pop%0d got=%h/%b exp=%h/1", k, Ret_Add, Ret_Valid, exp_v[k]);
         end
      end
      checks++;
      if (Empty !== 1'b1 || Err_Out !== 2'b00) begin
         failures++;
         $display("FAIL basic_end got empty=%b err=%b exp 1/00", Empty, Err_Out);
      end
   endtask

   task automatic test_ctx_isolation();
      step(1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0AAA);
      step(2, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0BBB);
      step(1, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0);
      checks++;
      if (Ret_Add !== 13'h0AAA) begin
         failures++;
         $display("FAIL iso_pop1 got=%h exp=0aaa", Ret_Add);
      end
      Ctx_Sel = 2'd2;
      #1;
      checks++;
      if (Depth_Out !== 7'd1) begin
         failures++;
         $display("FAIL iso_depth2 got=%0d exp=1", Depth_Out);
      end
      step(2, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0);
      checks++;
      if (Ret_Add !== 13'h0BBB) begin
         failures++;
         $display("FAIL iso_pop2 got=%h exp=0bbb", Ret_Add);
      end
   endtask

   task automatic test_tail_call();
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0010);
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 13'h0020);
      checks++;
      if (Ret_Add !== 13'h0010 || Ret_Valid !== 1'b1 || Depth_Out !== 7'd1) begin
         failures++;
         $display("FAIL tail_call got=%h/%b depth=%0d exp=0010/1 depth=1", Ret_Add, Ret_Valid, Depth_Out);
      end
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0);
      checks++;
      if (Ret_Add !== 13'h0020 || Depth_Out !== 7'd0) begin
         failures++;
         $display("FAIL tail_next got=%h depth=%0d exp=0020 depth=0", Ret_Add, Depth_Out);
      end
   endtask

   task automatic test_underflow();
      step(3, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0);
      checks++;
      if (Err_Out !== 2'b10 || Ret_Valid !== 1'b0 || Ret_Add !== 13'h0020) begin
         failures++;
         $display("FAIL udf_pop got err=%b rv=%b ret=%h exp 10/0/0020", Err_Out, Ret_Valid, Ret_Add);
      end
      step(3, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0);
      checks++;
      if (Err_Out !== 2'b00) begin
         failures++;
         $display("FAIL udf_clear got=%b exp=00", Err_Out);
      end
      // tail call on empty is an underflow too, and beats a same-cycle clear
      step(3, 1'b1, 1'b1, 1'b0, 1'b1, 13'h0055);
      checks++;
      if (Err_Out !== 2'b10 || Depth_Out !== 7'd0 || Ret_Valid !== 1'b0) begin
         failures++;
         $display("FAIL udf_tail got err=%b depth=%0d rv=%b exp 10/0/0", Err_Out, Depth_Out, Ret_Valid);
      end
      step(3, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0066);
      checks++;
      if (Err_Out !== 2'b10 || Depth_Out !== 7'd1) begin
         failures++;
         $display("FAIL udf_sticky got err=%b depth=%0d exp 10/1", Err_Out, Depth_Out);
      end
      step(3, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0);
   endtask

   task automatic test_overflow();
      logic [ADDR_W-1:0] exp_v;
      for (int v = 1; v <= DEPTH + 1; v++) step(0, 1'b1, 1'b0, 1'b0, 1'b0, ADDR_W'(v));
      checks++;
      if (Err_Out !== (WRAP ? 2'b00 : 2'b01) || Full !== 1'b1 || Depth_Out !== 7'd64) begin
         failures++;
         $display("FAIL ovf_status got err=%b full=%b depth=%0d exp err=%b full=1 depth=64",
                  Err_Out, Full, Depth_Out, (WRAP ? 2'b00 : 2'b01));
      end
      for (int k = 0; k < DEPTH; k++) begin
         exp_v = ADDR_W'((WRAP ? 65 : 64) - k);
         step(0, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0);
         checks++;
         if (Ret_Add !== exp_v || Ret_Valid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_pop%0d got=%0d/%b exp=%0d/1", k, Ret_Add, Ret_Valid, exp_v);
         end
      end
      checks++;
      if (Empty !== 1'b1 || Err_Out !== merr[0]) begin
         failures++;
         $display("FAIL ovf_end got empty=%b err=%b exp 1/%b", Empty, Err_Out, merr[0]);
      end
      step(0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0);
   endtask

   task automatic test_flush_reset();
      for (int k = 0; k < 3; k++) step(2, 1'b1, 1'b0, 1'b0, 1'b0, 13'($urandom()));
      step(2, 1'b0, 1'b1, 1'b1, 1'b0, 13'h0);
      checks++;
      if (Depth_Out !== 7'd0 || Ret_Valid !== 1'b0 || Err_Out !== 2'b00) begin
         failures++;
         $display("FAIL flush_pop got depth=%0d rv=%b err=%b exp 0/0/00", Depth_Out, Ret_Valid, Err_Out);
      end
      step(1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0123);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0456);
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0);
      // reset lands while a push is pending, before its falling edge
      Ctx_Sel = 2'd1; Push = 1'b1; Push_Data = 13'h0777;
      #2 Reset_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (Ret_Add !== 13'h0 || Ret_Valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_ret got=%h/%b exp=0000/0", Ret_Add, Ret_Valid);
      end
      @(posedge Slow_Clock);
      Push = 1'b0;
      for (int i = 0; i < NUM_CTX; i++) begin
         Ctx_Sel = i[1:0];
         #1;
         checks++;
         if (Empty !== 1'b1 || Depth_Out !== 7'd0) begin
            failures++;
            $display("FAIL midreset_ctx%0d got empty=%b depth=%0d exp 1/0", i, Empty, Depth_Out);
         end
      end
      @(posedge Slow_Clock);
      Reset_n = 1'b1;
   endtask

   task automatic test_random();
      int c, op, oc;
      bit pu, po, fl, ec;
      for (int n = 0; n < 600; n++) begin
         c  = int'($urandom_range(0, NUM_CTX - 1));
         op = int'($urandom_range(0, 19));
         ec = ($urandom_range(0, 15) == 0);
         fl = (op == 0);
         pu = (op >= 2 && op <= 9) || op == 17 || op == 18;
         po = (op >= 10 && op <= 18);
         step(c, pu, po, fl, ec, 13'($urandom()));
         checks++;
         if (Ret_Valid !== mrv || Ret_Add !== mret) begin
            failures++;
            $display("FAIL rand_ret n=%0d got=%h/%b exp=%h/%b", n, Ret_Add, Ret_Valid, mret, mrv);
         end
         checks++;
         if (Depth_Out !== CW'(mq[c].size()) || Err_Out !== merr[c] ||
             Full !== (mq[c].size() == DEPTH) || Empty !== (mq[c].size() == 0)) begin
            failures++;
            $display("FAIL rand_status n=%0d ctx=%0d got depth=%0d err=%b full=%b empty=%b exp depth=%0d err=%b",
                     n, c, Depth_Out, Err_Out, Full, Empty, mq[c].size(), merr[c]);
         end
         oc = int'($urandom_range(0, NUM_CTX - 1));
         Ctx_Sel = oc[1:0];
         #1;
         checks++;
         if (Depth_Out !== CW'(mq[oc].size()) || Err_Out !== merr[oc]) begin
            failures++;
            $display("FAIL rand_other n=%0d ctx=%0d got depth=%0d err=%b exp depth=%0d err=%b",
                     n, oc, Depth_Out, Err_Out, mq[oc].size(), merr[oc]);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      Ctx_Sel = 2'd0; Push = 1'b0; Pop = 1'b0; Flush = 1'b0; Err_Clear = 1'b0;
      Push_Data = 13'h0;
      test_reset();
      test_basic();
      test_ctx_isolation();
      test_tail_call();
      test_underflow();
      test_overflow();
      test_flush_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
